// File: rtl/kt_pkg.sv
// Shared types and constants for the KnightsTour serial command path.
package kt_pkg;

    typedef enum logic {HIGH, LOW} wrap_state_t;

    localparam logic [7:0] POS_ACK      = 8'hA5;
    localparam int         BAUD_DIV_DEF = 5208;
    localparam int         TMO_W        = 20;

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// 8N1 UART: one receiver with a held rx_rdy flag and one transmitter,
// sharing a common bit period of BAUD_DIV clocks.
module UART #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV + 1);

    logic          rx_meta, rx_sync, rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_sync) begin
                    // first sample lands mid start bit
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(BAUD_DIV / 2);
                    rx_bits <= '0;
                    rx_rdy  <= 1'b0;
                end
            end else if (rx_cnt == '0) begin
                rx_cnt  <= CW'(BAUD_DIV - 1);
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_shift;
                    rx_rdy  <= 1'b1;
                end else if (rx_bits != 4'd0) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt - CW'(1);
            end
        end
    end

    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [9:0]    tx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (trmt) begin
                    tx_busy  <= 1'b1;
                    tx_shift <= {1'b1, tx_data, 1'b0};
                    tx_cnt   <= '0;
                    tx_bits  <= '0;
                end
            end else if (tx_cnt == CW'(BAUD_DIV - 1)) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    assign TX = tx_shift[0];

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Pairs two received UART bytes into a 16-bit command with a ready/clear
// handshake and inter-byte timeout; forwards response bytes to the UART.
module uart_cmd_wrapper
    import kt_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int BYTE_TMO = 1 << 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BYTE_TMO - 1);

    wrap_state_t      state, nxt_state;
    logic [7:0]       rx_data;
    logic             rx_rdy, clr_rx_rdy, uart_tx_done;
    logic             cap_hi, cap_lo;
    logic [TMO_W-1:0] tmo_cnt;

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .TX        (TX),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .clr_rx_rdy(clr_rx_rdy),
        .trmt      (trmt),
        .tx_data   (resp),
        .tx_done   (uart_tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HIGH;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state  = state;
        clr_rx_rdy = 1'b0;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        unique case (state)
            HIGH: begin
                if (rx_rdy) begin
                    cap_hi     = 1'b1;
                    clr_rx_rdy = 1'b1;
                    nxt_state  = LOW;
                end
            end
            LOW: begin
                if (rx_rdy) begin
                    cap_lo     = 1'b1;
                    clr_rx_rdy = 1'b1;
                    nxt_state  = HIGH;
                end else if (tmo_cnt == TMO_LAST) begin
                    nxt_state = HIGH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            tmo_cnt <= '0;
            tx_done <= 1'b0;
        end else begin
            if (cap_hi)
                cmd[15:8] <= rx_data;
            if (cap_lo)
                cmd[7:0] <= rx_data;
            // completing a command beats a simultaneous consumer clear
            if (cap_lo)
                cmd_rdy <= 1'b1;
            else if (cap_hi || clr_cmd_rdy)
                cmd_rdy <= 1'b0;
            if (state == HIGH)
                tmo_cnt <= '0;
            else if (tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (trmt)
                tx_done <= 1'b0;
            else if (uart_tx_done)
                tx_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: random commands and responses
// checked against queued expectations by independent monitors.
module tb_uart_cmd_wrapper;

    localparam int B   = 16;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        trmt = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic        prev_rdy = 1'b0;

    uart_cmd_wrapper #(.BAUD_DIV(B), .BYTE_TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .trmt       (trmt),
        .resp       (resp),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // command monitor: every rising cmd_rdy must match the next expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy <= 1'b0;
        end else begin
            if (cmd_rdy && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd_rdy", {16'h0, cmd}, 32'hFFFF_FFFF);
                end else begin
                    chk("cmd", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
                end
            end
            prev_rdy <= cmd_rdy;
        end
    end

    // response monitor: decode each TX frame and compare
    always begin
        @(negedge TX);
        if (rst_n) begin
            logic [7:0] got;
            logic       st, sp;
            repeat (B / 2) @(negedge clk);
            st = TX;
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(negedge clk);
                got[i] = TX;
            end
            repeat (B) @(negedge clk);
            sp = TX;
            chk("tx_start", {31'h0, st}, 32'h0);
            chk("tx_stop", {31'h0, sp}, 32'h1);
            if (tx_q.size() == 0)
                chk("unexpected_tx_frame", {24'h0, got}, 32'hFFFF_FFFF);
            else
                chk("tx_byte", {24'h0, got}, {24'h0, tx_q.pop_front()});
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic [15:0] c, input int gap);
        exp_q.push_back(c);
        send_byte(c[15:8]);
        repeat (gap) @(negedge clk);
        send_byte(c[7:0]);
    endtask

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (!cmd_rdy && n < 20 * B) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy)
            chk(name, 32'h0, 32'h1);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_resp(input logic [7:0] r, input logic mid_trmt);
        int n;
        tx_q.push_back(r);
        @(negedge clk);
        resp = r;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        n = 1;
        while (!tx_done && n < 12 * B) begin
            trmt = mid_trmt && (n == 5 * B);
            resp = mid_trmt ? 8'h3C : r;
            @(negedge clk);
            n++;
        end
        trmt = 1'b0;
        checks++;
        if (n < 10 * B || n > 10 * B + 2) begin
            errors++;
            $display("FAIL tx_done_latency: got %0d expected %0d", n, 10 * B + 1);
        end
        repeat (3 * B) @(negedge clk);
    endtask

    initial begin
        logic [7:0] hi;
        repeat (3) @(negedge clk);
        chk("rst_cmd", {16'h0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_TX", {31'h0, TX}, 32'h1);
        chk("rst_tx_done", {31'h0, tx_done}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_cmd(16'h47F3, 3);
        wait_rdy("rdy_47F3");
        chk("rdy_held", {31'h0, cmd_rdy}, 32'h1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("clr_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("cmd_hold", {16'h0, cmd}, 32'h47F3);
        send_cmd(16'h2000, 10);
        wait_rdy("rdy_2000");

        // lone high byte then a long gap: nothing may be delivered
        send_byte(8'h47);
        repeat (TMO + 200) @(negedge clk);
        chk("tmo_no_rdy", {31'h0, cmd_rdy}, 32'h0);
        send_cmd(16'h2000, 0);
        wait_rdy("rdy_after_tmo");

        send_resp(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++)
            send_resp(8'($urandom), 1'b0);

        send_byte(8'h47);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd", {16'h0, cmd}, 32'h0);
        chk("midrst_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("midrst_TX", {31'h0, TX}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_cmd(16'h1234, 5);
        wait_rdy("rdy_1234");

        // consumer clear overlapping the high-byte capture
        hi = 8'($urandom);
        clr_cmd_rdy = 1'b1;
        send_byte(hi);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("clr_vs_hi_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("clr_vs_hi_byte", {24'h0, cmd[15:8]}, {24'h0, hi});
        exp_q.push_back({hi, 8'h5A});
        send_byte(8'h5A);
        wait_rdy("rdy_after_clr");

        // consumer clear held through the low-byte completion
        clr_cmd_rdy = 1'b1;
        send_cmd(16'($urandom), 2);
        repeat (4) @(negedge clk);
        clr_cmd_rdy = 1'b0;

        for (int i = 0; i < 12; i++) begin
            send_cmd(16'($urandom), int'($urandom_range(0, 200)));
            wait_rdy("rdy_random");
            if ($urandom_range(0, 1) == 1) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
            end
        end

        repeat (4 * B) @(negedge clk);
        chk("cmd_queue_empty", exp_q.size(), 32'h0);
        chk("tx_queue_empty", tx_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Receive-side command assembler and response transmitter that sits between the robot's serial RX/TX pins and the command processor inside `KnightsTour`. It takes two UART bytes from the remote and delivers them as one 16-bit command, high byte first, with a `cmd_rdy` flag. It also serialises the 8-bit acknowledge back to the remote. The embedded `UART` sub-module does the serial bit timing; this block owns byte pairing, the ready/clear handshake and the inter-byte timeout.

## Interface
Parameters:
- `BAUD_DIV`, default 5208: clocks per bit, passed to the `UART` sub-module (50 MHz, 9600 baud).
- `BYTE_TMO`, default 2^20: clocks allowed between the high and low byte before the partial command is discarded.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `RX`  in  1  serial input from the remote (idle high).
- `TX`  out  1  serial output to the remote (idle high).
- `cmd`  out  16  assembled command, {high byte, low byte}.
- `cmd_rdy`  out  1  `cmd` holds a valid, unconsumed command.
- `clr_cmd_rdy`  in  1  consumer pulse: command taken.
- `trmt`  in  1  one-cycle pulse: send `resp`.
- `resp`  in  8  response byte; sampled when `trmt` is high.
- `tx_done`  out  1  last response byte has finished.

## Operation
- State machine, two states:
  - `HIGH`: waiting for the first byte.
  - `LOW`: high byte captured, waiting for the second.
- Reset: state `HIGH`, `cmd`=16'h0000, `cmd_rdy`=0, `TX`=1, `tx_done`=0, timeout counter=0.
- `HIGH`, UART `rx_rdy` high:
  - Capture `rx_data` into `cmd[15:8]`.
  - Pulse `clr_rx_rdy`.
  - Clear `cmd_rdy`, so a new command invalidates any stale one.
  - Clear the timeout counter and go to `LOW`.
- `LOW`, `rx_rdy` high:
  - Capture into `cmd[7:0]`.
  - Pulse `clr_rx_rdy`.
  - Set `cmd_rdy` and go to `HIGH`.
- `LOW`, no byte: the timeout counter increments each clock. When it reaches `BYTE_TMO`-1, go to `HIGH`, leave `cmd_rdy` at 0 and discard the high byte.
- `cmd_rdy` is cleared by `clr_cmd_rdy`. If `clr_cmd_rdy` and a high byte arrive in the same cycle, the result is `cmd_rdy`=0 and the high byte is captured. If a low byte completes in the same cycle as `clr_cmd_rdy`, set wins.
- `cmd[15:0]` holds its value until overwritten; it is never cleared except by reset.
- TX path:
  - `trmt` is passed straight to `UART`.
  - `tx_done` is cleared by `trmt` and set by the UART's transmit-complete.
  - A `trmt` while a transmission is in progress is ignored; the current byte completes untouched.
- Reset mid-byte or mid-command: all state is dropped and the block returns to `HIGH` with `cmd_rdy`=0.

## Timing
- `cmd_rdy` rises one clock after the UART's `rx_rdy` for the low byte. That is about 10·`BAUD_DIV` clocks after that byte's start bit.
- `clr_rx_rdy` is a single-cycle pulse, registered in the same cycle the byte is captured.
- `cmd` is stable from the cycle `cmd_rdy` rises until the next high byte is captured.
- `TX` start bit begins within 1 clock of `trmt`. A frame takes 10·`BAUD_DIV` clocks; `tx_done` rises in the clock after the stop bit ends.
- Timeout counter is 20 bits wide and saturates; it is not free-running in `HIGH`.

## Structure
- Shared package `kt_pkg`:
  - state enum `wrap_state_t` {`HIGH`, `LOW`};
  - `POS_ACK` = 8'hA5;
  - default `BAUD_DIV` constant.
- Sub-module: `UART` (existing `UART_rx`/`UART_tx` pair), instantiated once.
- Wrapper logic: FSM, the two byte registers, the `cmd_rdy` flop and the timeout counter, all in this block.

## Test plan
- Reset, then two bytes 8'h47 and 8'hF3 on `RX` → `cmd`=16'h47F3, `cmd_rdy`=1 one clock after the second `rx_rdy`; state back at `HIGH`.
- With `cmd_rdy`=1, pulse `clr_cmd_rdy` → `cmd_rdy`=0 next clock and `cmd` still 16'h47F3. Then send 8'h20, 8'h00 → `cmd`=16'h2000, `cmd_rdy`=1.
- Send only 8'h47, then idle for more than `BYTE_TMO` clocks (override to 1000), then 8'h20 and 8'h00 → `cmd`=16'h2000, and no `cmd_rdy` pulse occurs during the gap.
- `trmt` with `resp`=8'hA5 → `TX` frame with LSB-first data 8'hA5; `tx_done` rises after 10·`BAUD_DIV` clocks. A second `trmt` mid-frame must not corrupt the frame.
- Assert `rst_n` low while in `LOW` after 8'h47 → `cmd`=0, `cmd_rdy`=0, `TX`=1. Next pair 8'h12, 8'h34 → 16'h1234.
- `clr_cmd_rdy` in the same cycle as a new high byte capture → `cmd_rdy`=0 and high byte latched. Completing the low byte then gives `cmd_rdy`=1.
